// File: rtl/zb_fifo_param_if.sv
// zb_fifo_param_if: write/read/flush handshake and status bundle for zb_fifo_param.
// The FIFO connects through the slave modport. The producer/consumer side connects
// through the master modport.
interface zb_fifo_param_if #(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] inData;
    logic                  inWriteEnable;
    logic                  inReadEnable;
    logic                  inFlush;
    logic [DATA_WIDTH-1:0] outData;
    logic                  outValid;
    logic                  outFull;
    logic                  outEmpty;
    logic                  outAlmostFull;
    logic                  outAlmostEmpty;
    logic [LW-1:0]         outLevel;
    logic                  outOverflow;
    logic                  outUnderflow;

    modport slave (
        input  inData, inWriteEnable, inReadEnable, inFlush,
        output outData, outValid, outFull, outEmpty, outAlmostFull,
               outAlmostEmpty, outLevel, outOverflow, outUnderflow
    );

    modport master (
        output inData, inWriteEnable, inReadEnable, inFlush,
        input  outData, outValid, outFull, outEmpty, outAlmostFull,
               outAlmostEmpty, outLevel, outOverflow, outUnderflow
    );
endinterface

// File: rtl/zb_fifo_param.sv
// zb_fifo_param: parametrised synchronous FIFO that sits between the routing fabric
// and the modem datapath. It provides an occupancy count, almost-full/almost-empty
// thresholds, a synchronous flush, and sticky overflow/underflow flags.
// Optional feature: define ZB_FIFO_FWFT_EN for first-word-fall-through (0-cycle read).
// Without it, reads are registered with 1-cycle latency.
module zb_fifo_param #(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic              inClock,
    input  logic              inReset,
    zb_fifo_param_if.slave    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    logic full, empty, rd_acc, wr_acc;

    // Status is a pure function of the level register.
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);

    // A read is never accepted from an empty FIFO. A write into a full FIFO is
    // accepted only when a read frees a slot on the same edge.
    assign rd_acc = bus.inReadEnable && !empty;
    assign wr_acc = bus.inWriteEnable && (!full || rd_acc);

    assign bus.outFull        = full;
    assign bus.outEmpty       = empty;
    assign bus.outAlmostFull  = (level_q >= LW'(AF_LEVEL));
    assign bus.outAlmostEmpty = (level_q <= LW'(AE_LEVEL));
    assign bus.outLevel       = level_q;
    assign bus.outOverflow    = ovf_q;
    assign bus.outUnderflow   = udf_q;

    // Storage array has no reset, and flush leaves its contents in place.
    always_ff @(posedge inClock) begin
        if (wr_acc && !bus.inFlush) begin
            mem_q[wr_ptr_q] <= bus.inData;
        end
    end

    // Next state for pointers, level and sticky error flags. Flush overrides everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q | (bus.inWriteEnable & ~wr_acc);
        udf_d    = udf_q | (bus.inReadEnable & ~rd_acc);
        if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (bus.inFlush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

`ifdef ZB_FIFO_FWFT_EN
    // Head word falls through from the array. Zero is shown when the FIFO is empty,
    // so flush and reset present outData=0.
    always_comb begin
        bus.outData  = '0;
        bus.outValid = !empty;
        if (!empty) bus.outData = mem_q[rd_ptr_q];
    end
`else
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;

    // Registered read port. outValid pulses for the single cycle after an accepted
    // read, while outData holds the last popped word until the next read.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        if (rd_acc) begin
            rdata_d  = mem_q[rd_ptr_q];
            rvalid_d = 1'b1;
        end
        if (bus.inFlush) begin
            rdata_d  = '0;
            rvalid_d = 1'b0;
        end
    end

    // Read data register with asynchronous active-low reset.
    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.outData  = rdata_q;
    assign bus.outValid = rvalid_q;
`endif
endmodule

// File: tb/tb_zb_fifo_param.sv
// tb_zb_fifo_param: directed vector table for zb_fifo_param (DATA_WIDTH=4, DEPTH=8,
// AF_LEVEL=6, AE_LEVEL=2), plus hand-written sequences for async reset and FWFT.
module tb_zb_fifo_param;
    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    zb_fifo_param_if #(.DATA_WIDTH(4), .DEPTH(8)) bus ();

    zb_fifo_param #(.DATA_WIDTH(4), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
        .inClock (clk),
        .inReset (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr, rd, fl;
        logic [3:0] din;
        logic [3:0] ed;
        logic       ev;
        logic [3:0] el;
        logic       eo, eu;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t V(logic wr, logic rd, logic fl, logic [3:0] din,
                               logic [3:0] ed, logic ev, logic [3:0] el,
                               logic eo, logic eu);
        vec_t v;
        v.wr = wr; v.rd = rd; v.fl = fl; v.din = din;
        v.ed = ed; v.ev = ev; v.el = el; v.eo = eo; v.eu = eu;
        return v;
    endfunction

    // Flags are derived from the expected level using the flag definitions.
    function automatic logic [14:0] model(logic [3:0] d, logic v, logic [3:0] l,
                                          logic o, logic u);
        return {d, v, l, (l == 4'd8), (l == 4'd0), (l >= 4'd6), (l <= 4'd2), o, u};
    endfunction

    function automatic logic [14:0] snap();
        return {bus.outData, bus.outValid, bus.outLevel, bus.outFull, bus.outEmpty,
                bus.outAlmostFull, bus.outAlmostEmpty, bus.outOverflow, bus.outUnderflow};
    endfunction

    task automatic chk(string nm, logic [14:0] act, logic [14:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {d,v,lvl,f,e,af,ae,ov,un}=%b want %b", nm, act, exp);
        end
    endtask

    task automatic drive(logic wr, logic rd, logic fl, logic [3:0] din);
        bus.inWriteEnable = wr;
        bus.inReadEnable  = rd;
        bus.inFlush       = fl;
        bus.inData        = din;
    endtask

    task automatic step(logic wr, logic rd, logic fl, logic [3:0] din);
        drive(wr, rd, fl, din);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        #12;
        chk("reset_state", snap(), model(4'h0, 1'b0, 4'd0, 1'b0, 1'b0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifndef ZB_FIFO_FWFT_EN
        // wr rd fl din | data valid level ovf udf
        vecs.push_back(V(0,0,0,4'h0, 4'h0,0,4'd0,0,0));   // idle
        vecs.push_back(V(1,0,0,4'h1, 4'h0,0,4'd1,0,0));
        vecs.push_back(V(1,0,0,4'h4, 4'h0,0,4'd2,0,0));
        vecs.push_back(V(1,0,0,4'h9, 4'h0,0,4'd3,0,0));   // AE drops at 3
        vecs.push_back(V(0,1,0,4'h0, 4'h1,1,4'd2,0,0));
        vecs.push_back(V(0,1,0,4'h0, 4'h4,1,4'd1,0,0));
        vecs.push_back(V(0,1,0,4'h0, 4'h9,1,4'd0,0,0));
        vecs.push_back(V(0,0,0,4'h0, 4'h9,0,4'd0,0,0));   // valid is one cycle, data holds
        for (int i = 0; i < 8; i++)
            vecs.push_back(V(1,0,0,4'(i), 4'h9,0,4'(i+1),0,0));
        vecs.push_back(V(1,0,0,4'hF, 4'h9,0,4'd8,1,0));   // overflow, level stays 8
        vecs.push_back(V(1,1,0,4'hA, 4'h0,1,4'd8,1,0));   // full r+w, pops 0x0
        for (int k = 1; k < 8; k++)
            vecs.push_back(V(0,1,0,4'h0, 4'(k),1,4'(8-k),1,0));
        vecs.push_back(V(0,1,0,4'h0, 4'hA,1,4'd0,1,0));   // wrapped word
        vecs.push_back(V(0,0,0,4'h0, 4'hA,0,4'd0,1,0));
        vecs.push_back(V(0,1,0,4'h0, 4'hA,0,4'd0,1,1));   // underflow
        vecs.push_back(V(0,0,0,4'h0, 4'hA,0,4'd0,1,1));   // sticky
        vecs.push_back(V(0,0,1,4'h0, 4'h0,0,4'd0,0,0));   // flush clears
        vecs.push_back(V(1,1,0,4'h5, 4'h0,0,4'd1,0,1));   // empty r+w: write only
        vecs.push_back(V(0,1,0,4'h0, 4'h5,1,4'd0,0,1));
        vecs.push_back(V(1,0,1,4'h6, 4'h0,0,4'd0,0,0));   // flush beats write

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].fl, vecs[i].din);
            chk($sformatf("vec%0d", i), snap(),
                model(vecs[i].ed, vecs[i].ev, vecs[i].el, vecs[i].eo, vecs[i].eu));
        end
`else
        step(1'b1, 1'b0, 1'b0, 4'h3);
        chk("fwft_fallthrough", snap(), model(4'h3, 1'b1, 4'd1, 1'b0, 1'b0));
        step(1'b1, 1'b0, 1'b0, 4'h7);
        chk("fwft_head_holds", snap(), model(4'h3, 1'b1, 4'd2, 1'b0, 1'b0));
        step(1'b0, 1'b1, 1'b0, 4'h0);
        chk("fwft_advance", snap(), model(4'h7, 1'b1, 4'd1, 1'b0, 1'b0));
        step(1'b0, 1'b1, 1'b0, 4'h0);
        chk("fwft_drain", snap(), model(4'h0, 1'b0, 4'd0, 1'b0, 1'b0));
        step(1'b1, 1'b1, 1'b0, 4'h5);
        chk("fwft_empty_rw", snap(), model(4'h5, 1'b1, 4'd1, 1'b0, 1'b1));
        step(1'b0, 1'b0, 1'b1, 4'h0);
        chk("fwft_flush", snap(), model(4'h0, 1'b0, 4'd0, 1'b0, 1'b0));
`endif

        // Fill to 5, then drop reset partway through a write burst.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 4'(i + 1));
        chk("fill5_level", {11'd0, bus.outLevel}, 15'd5);
        drive(1'b1, 1'b0, 1'b0, 4'hE);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_now", snap(), model(4'h0, 1'b0, 4'd0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        chk("reset_held_edge", snap(), model(4'h0, 1'b0, 4'd0, 1'b0, 1'b0));
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_idle", snap(), model(4'h0, 1'b0, 4'd0, 1'b0, 1'b0));
        step(1'b1, 1'b0, 1'b0, 4'hC);
`ifndef ZB_FIFO_FWFT_EN
        chk("post_reset_wr", snap(), model(4'h0, 1'b0, 4'd1, 1'b0, 1'b0));
        step(1'b0, 1'b1, 1'b0, 4'h0);
        chk("post_reset_rd", snap(), model(4'hC, 1'b1, 4'd0, 1'b0, 1'b0));
`else
        chk("post_reset_wr", snap(), model(4'hC, 1'b1, 4'd1, 1'b0, 1'b0));
        step(1'b0, 1'b1, 1'b0, 4'h0);
        chk("post_reset_rd", snap(), model(4'h0, 1'b0, 4'd0, 1'b0, 1'b0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
